horizontal_tf_addr_ctrl: RTL

Sequencer for the radix-16 horizontal twiddle-factor path of the 16384-point FFT. On a start pulse it walks the butterfly counter for the selected stage and drives one shared read address and enable to all eight horizontal twiddle ROMs (ROM0 single-entry, ROM1–ROM7 packed pairs). It also produces a valid strobe aligned with ROM data, so the downstream unpack mux outputs tf1–tf15 can be consumed directly by the butterfly multipliers. Stall input supports back-pressure from the butterfly pipeline.

---
 rtl/tf_ctrl_pkg.sv | 19 +
 rtl/tf_valid_pipe.sv | 46 ++++
 rtl/horizontal_tf_addr_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/tf_ctrl_pkg.sv
// Shared constants, FSM encodings and address helper for the horizontal
// twiddle-factor controller of the 16384-point radix-16 FFT.
package tf_ctrl_pkg;

  localparam int unsigned FFT_N      = 16384;
  localparam int unsigned RADIX_LOG2 = 4;
  localparam int unsigned TF_ADDR_W  = 10;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  // Twiddle index for a butterfly: later stages use coarser twiddle spacing.
  function automatic logic [TF_ADDR_W-1:0] tf_addr(input logic [TF_ADDR_W-1:0] cnt,
                                                    input logic [1:0]           stage);
    return cnt << (RADIX_LOG2 * stage);
  endfunction

endpackage

// File: rtl/tf_valid_pipe.sv
// ROM_LAT-deep shift register carrying the read-valid and last-read flags so
// they line up with ROM data.
module tf_valid_pipe #(
  parameter int unsigned ROM_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  input  logic last_in,
  output logic valid_out,
  output logic last_out,
  output logic last_pre
);

  logic [ROM_LAT-1:0] v_q;
  logic [ROM_LAT-1:0] l_q;

  if (ROM_LAT == 1) begin : g_single
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        l_q <= '0;
      end else begin
        v_q <= valid_in;
        l_q <= last_in;
      end
    end
    assign last_pre = last_in;
  end else begin : g_multi
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        l_q <= '0;
      end else begin
        v_q <= {v_q[ROM_LAT-2:0], valid_in};
        l_q <= {l_q[ROM_LAT-2:0], last_in};
      end
    end
    // Value that lands in the last stage on the next edge.
    assign last_pre = l_q[ROM_LAT-2];
  end

  assign valid_out = v_q[ROM_LAT-1];
  assign last_out  = l_q[ROM_LAT-1];

endmodule

// File: rtl/horizontal_tf_addr_ctrl.sv
// Walks the butterfly counter of one radix-16 stage and drives the shared
// address/enable of the eight horizontal twiddle ROMs plus an aligned valid.
module horizontal_tf_addr_ctrl
  import tf_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CNT_MAX    = 1023,
  parameter int unsigned ROM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            stage,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  output logic                  tf_valid,
  output logic                  busy,
  output logic                  done
);

  logic [1:0]            state_q, state_d;
  logic [1:0]            stage_q;
  logic [ADDR_WIDTH-1:0] bf_cnt_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic                  rom_en_q;
  logic                  last_q;
  logic                  busy_q;
  logic                  accept;
  logic                  issue;
  logic                  is_last;
  logic                  last_pre;

  // A start coinciding with done is dropped even though the FSM is back in IDLE.
  assign accept  = start && (state_q == IDLE) && !done;
  assign issue   = (state_q == RUN) && !stall;
  assign is_last = (bf_cnt_q == ADDR_WIDTH'(CNT_MAX));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (issue && is_last) state_d = FLUSH;
      FLUSH:   if (last_pre) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      bf_cnt_q   <= '0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != IDLE);
      rom_en_q <= issue;
      last_q   <= issue && is_last;
      if (accept) begin
        stage_q  <= stage;
        bf_cnt_q <= '0;
      end
      if (issue) begin
        rom_addr_q <= ADDR_WIDTH'(tf_addr(TF_ADDR_W'(bf_cnt_q), stage_q));
        bf_cnt_q   <= bf_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  tf_valid_pipe #(
    .ROM_LAT (ROM_LAT)
  ) u_valid_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (rom_en_q),
    .last_in   (last_q),
    .valid_out (tf_valid),
    .last_out  (done),
    .last_pre  (last_pre)
  );

  assign rom_addr = rom_addr_q;
  assign rom_en   = rom_en_q;
  assign busy     = busy_q;

endmodule
